// File: rtl/video_timing_gen.sv
// Raster timing master: free-running h/v counters drive pixel coordinates, and
// one output register stage aligns the sampled RGB with sync, de and frame_start.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       pxl_clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits wide so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam bit SYNC_OFF = ~SYNC_POL;

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;

  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = 10'd0;
      v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      h_reg <= 10'd0;
      v_reg <= 10'd0;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

  assign x = h_reg;
  assign y = v_reg;

  logic [10:0] h_ext, v_ext;
  logic        active, hs, vs, origin;

  assign h_ext  = {1'b0, h_reg};
  assign v_ext  = {1'b0, v_reg};
  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs     = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs     = (v_ext >= VS_BEG) && (v_ext < VS_END);
  assign origin = (h_reg == 10'd0) && (v_reg == 10'd0);

  logic de_reg, hsync_reg, vsync_reg, frame_start_reg;

  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      de_reg          <= 1'b0;
      hsync_reg       <= SYNC_OFF;
      vsync_reg       <= SYNC_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      de_reg          <= active;
      hsync_reg       <= hs ? SYNC_POL : SYNC_OFF;
      vsync_reg       <= vs ? SYNC_POL : SYNC_OFF;
      frame_start_reg <= origin;
    end
  end

  assign de          = de_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;

  // Colour channels share one register template; blanking forces black.
  logic [7:0] pix_in [3];
  assign pix_in[0] = r_in;
  assign pix_in[1] = g_in;
  assign pix_in[2] = b_in;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] chan_reg;
      always_ff @(posedge pxl_clk) begin
        if (rst)
          chan_reg <= 8'd0;
        else
          chan_reg <= active ? pix_in[gi] : 8'd0;
      end
    end
  endgenerate

  assign r_out = g_chan[0].chan_reg;
  assign g_out = g_chan[1].chan_reg;
  assign b_out = g_chan[2].chan_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two reduced-size rasters (both sync polarities) and one
// full 640x480 raster, checked every cycle against an independent model.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Reduced raster: 16+2+4+3 = 25 per line, 6+1+2+2 = 11 lines, 275 per frame
  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 6,  SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
  localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

  typedef struct packed {
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        fs;
    logic [23:0] rgb;
  } out_t;

  // DUT a: small, active-low sync
  logic [9:0] x_a, y_a;
  logic [7:0] r_a, g_a, b_a, ro_a, go_a, bo_a;
  logic       hs_a, vs_a, de_a, fs_a;
  assign r_a = x_a[7:0];
  assign g_a = y_a[7:0];
  assign b_a = 8'h5A;

  video_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b0)
  ) dut_a (
    .pxl_clk(clk), .rst(rst), .x(x_a), .y(y_a),
    .r_in(r_a), .g_in(g_a), .b_in(b_a),
    .r_out(ro_a), .g_out(go_a), .b_out(bo_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .frame_start(fs_a)
  );

  // DUT b: small, active-high sync
  logic [9:0] x_b, y_b;
  logic [7:0] r_b, g_b, b_b, ro_b, go_b, bo_b;
  logic       hs_b, vs_b, de_b, fs_b;
  assign r_b = x_b[7:0];
  assign g_b = y_b[7:0];
  assign b_b = 8'h5A;

  video_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)
  ) dut_b (
    .pxl_clk(clk), .rst(rst), .x(x_b), .y(y_b),
    .r_in(r_b), .g_in(g_b), .b_in(b_b),
    .r_out(ro_b), .g_out(go_b), .b_out(bo_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame_start(fs_b)
  );

  // DUT c: default 640x480 timing
  logic [9:0] x_c, y_c;
  logic [7:0] r_c, g_c, b_c, ro_c, go_c, bo_c;
  logic       hs_c, vs_c, de_c, fs_c;
  assign r_c = x_c[7:0];
  assign g_c = y_c[7:0];
  assign b_c = 8'h5A;

  video_timing_gen dut_c (
    .pxl_clk(clk), .rst(rst), .x(x_c), .y(y_c),
    .r_in(r_c), .g_in(g_c), .b_in(b_c),
    .r_out(ro_c), .g_out(go_c), .b_out(bo_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .frame_start(fs_c)
  );

  int tests = 0;
  int fails = 0;

  out_t q_a[$], q_b[$], q_c[$];
  int   mh_s = 0, mv_s = 0;   // model counters, small rasters
  int   mh_c = 0, mv_c = 0;   // model counters, full raster

  function automatic out_t model(int h, int v, int ha, int hf, int hsw,
                                 int va, int vf, int vsw, bit pol);
    out_t o;
    bit   act;
    act     = (h < ha) && (v < va);
    o.de    = act;
    o.hsync = ((h >= ha + hf) && (h < ha + hf + hsw)) ? pol : ~pol;
    o.vsync = ((v >= va + vf) && (v < va + vf + vsw)) ? pol : ~pol;
    o.fs    = (h == 0) && (v == 0);
    o.rgb   = act ? {h[7:0], v[7:0], 8'h5A} : 24'd0;
    return o;
  endfunction

  function automatic out_t reset_out(bit pol);
    out_t o;
    o.de    = 1'b0;
    o.hsync = ~pol;
    o.vsync = ~pol;
    o.fs    = 1'b0;
    o.rgb   = 24'd0;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: push expected outputs, advance the model, pop and compare after the edge.
  task automatic tick(input logic do_rst);
    out_t ea, eb, ec;
    rst = do_rst;
    if (do_rst) begin
      q_a.push_back(reset_out(1'b0));
      q_b.push_back(reset_out(1'b1));
      q_c.push_back(reset_out(1'b0));
      mh_s = 0; mv_s = 0; mh_c = 0; mv_c = 0;
    end else begin
      q_a.push_back(model(mh_s, mv_s, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0));
      q_b.push_back(model(mh_s, mv_s, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b1));
      q_c.push_back(model(mh_c, mv_c, 640, 16, 96, 480, 10, 2, 1'b0));
      if (mh_s == SH_T - 1) begin
        mh_s = 0;
        mv_s = (mv_s == SV_T - 1) ? 0 : mv_s + 1;
      end else mh_s++;
      if (mh_c == 799) begin
        mh_c = 0;
        mv_c = (mv_c == 524) ? 0 : mv_c + 1;
      end else mh_c++;
    end
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ec = q_c.pop_front();
    check($sformatf("out_a@%0d,%0d", x_a, y_a), 32'({de_a, hs_a, vs_a, fs_a, ro_a, go_a, bo_a}), 32'(ea));
    check($sformatf("out_b@%0d,%0d", x_b, y_b), 32'({de_b, hs_b, vs_b, fs_b, ro_b, go_b, bo_b}), 32'(eb));
    check($sformatf("out_c@%0d,%0d", x_c, y_c), 32'({de_c, hs_c, vs_c, fs_c, ro_c, go_c, bo_c}), 32'(ec));
    check("xy_a", 32'({x_a, y_a}), 32'({10'(mh_s), 10'(mv_s)}));
    check("xy_c", 32'({x_c, y_c}), 32'({10'(mh_c), 10'(mv_c)}));
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, de_last;
    int fs_cnt, fs_prev, fs_period, vs_a_cnt, vs_b_cnt;
    int steps;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("rst_hsync_c", 32'(hs_c), 32'd1);
    check("rst_vsync_c", 32'(vs_c), 32'd1);
    check("rst_de_c", 32'(de_c), 32'd0);
    $display("[TB] reset held 3 cycles: de=%0d hsync=%0d vsync=%0d", de_c, hs_c, vs_c);

    // One full-size line; the small rasters run ~2.9 frames meanwhile
    de_cnt = 0; hs_cnt = 0; hs_first = -1; de_last = -1;
    fs_cnt = 0; fs_prev = -1; fs_period = 0; vs_a_cnt = 0; vs_b_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1'b0);
      if (i == 0) begin
        check("first_de", 32'(de_c), 32'd1);
        check("first_fs", 32'(fs_c), 32'd1);
      end
      if (de_c) begin de_cnt++; de_last = i; end
      if (!hs_c) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (fs_a) begin
        if (fs_prev >= 0) fs_period = i - fs_prev;
        fs_prev = i;
        fs_cnt++;
      end
      if (!vs_a) vs_a_cnt++;
      if (vs_b) vs_b_cnt++;
    end
    check("line_de_count", 32'(de_cnt), 32'd640);
    check("line_hsync_count", 32'(hs_cnt), 32'd96);
    check("hsync_gap_after_de", 32'(hs_first - de_last - 1), 32'd16);
    check("line_period_wrap", 32'({x_c, y_c}), 32'({10'd0, 10'd1}));
    check("small_fs_count", 32'(fs_cnt), 32'd3);
    check("small_fs_period", 32'(fs_period), 32'(SH_T * SV_T));
    check("small_vsync_low", 32'(vs_a_cnt), 32'(3 * SV_S * SH_T));
    check("small_vsync_high_pol1", 32'(vs_b_cnt), 32'(3 * SV_S * SH_T));
    $display("[TB] line: de=%0d hsync=%0d gap=%0d; small frames fs=%0d period=%0d",
             de_cnt, hs_cnt, hs_first - de_last - 1, fs_cnt, fs_period);

    // Mid-frame reset on the small raster at x=10, y=3
    steps = 0;
    while (!(x_a == 10'd10 && y_a == 10'd3) && steps < 400) begin
      tick(1'b0);
      steps++;
    end
    check("reach_mid_frame", 32'({x_a, y_a}), 32'({10'd10, 10'd3}));
    tick(1'b1);
    check("midrst_de", 32'(de_a), 32'd0);
    check("midrst_hsync_pol1", 32'(hs_b), 32'd0);
    $display("[TB] mid-frame reset: x=%0d y=%0d de=%0d", x_a, y_a, de_a);

    de_cnt = 0;
    for (int i = 0; i < SH_T; i++) begin
      tick(1'b0);
      if (i == 0) check("midrst_fs", 32'(fs_a), 32'd1);
      if (de_a) de_cnt++;
    end
    check("midrst_first_line_de", 32'(de_cnt), 32'(SH_A));
    $display("[TB] first line after mid-frame reset: de=%0d", de_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
